// File: rtl/wb_rr_arbiter.sv
// N-master to single-slave Wishbone arbiter. One master owns the bus per tenure,
// picked by round-robin or fixed priority, and keeps it until it drops cyc.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort hung slave accesses with err.
module wb_rr_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           wb_clk,
    input  logic                           wb_rst_n,
    input  logic [NUM_MASTERS*AW-1:0]      m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]      m_dat_i,
    input  logic [NUM_MASTERS*(DW/8)-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]         m_cyc_i,
    input  logic [NUM_MASTERS-1:0]         m_stb_i,
    input  logic [NUM_MASTERS-1:0]         m_we_i,
    output logic [DW-1:0]                  m_dat_o,
    output logic [NUM_MASTERS-1:0]         m_ack_o,
    output logic [NUM_MASTERS-1:0]         m_err_o,
    output logic [NUM_MASTERS-1:0]         m_gnt_o,
    output logic [AW-1:0]                  s_adr_o,
    output logic [DW-1:0]                  s_dat_o,
    output logic [(DW/8)-1:0]              s_sel_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    output logic                           s_we_o,
    input  logic [DW-1:0]                  s_dat_i,
    input  logic                           s_ack_i,
    input  logic                           s_err_i
);

    localparam int unsigned SW  = DW / 8;
    localparam int unsigned OW  = $clog2(NUM_MASTERS);
    localparam int unsigned OW1 = OW + 1;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;
`else
    typedef enum logic [0:0] {StIdle, StGrant} state_e;
`endif

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [OW-1:0] winner;
    logic          own_cyc;
    logic          own_stb;
    logic          timeout_hit;

    assign own_cyc = m_cyc_i[owner_q];
    assign own_stb = m_stb_i[owner_q];
    assign m_dat_o = s_dat_i;

    // Arbitration: later loop iterations overwrite, so the lowest offset/index wins.
    always_comb begin
        logic [OW1-1:0] idx;
        winner = '0;
        idx    = '0;
        if (PRIORITY_MODE == 1) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (m_cyc_i[i]) winner = OW'(i);
            end
        end else begin
            for (int i = NUM_MASTERS; i >= 1; i--) begin
                idx = OW1'(last_q) + OW1'(i);
                if (idx >= OW1'(NUM_MASTERS)) idx = idx - OW1'(NUM_MASTERS);
                if (m_cyc_i[idx[OW-1:0]]) winner = idx[OW-1:0];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       stall;

    // Stall is measured against the unforced slave strobe of the current owner.
    assign stall       = (state_q == StGrant) && own_cyc && own_stb && !s_ack_i && !s_err_i;
    assign timeout_hit = stall && (wdog_q == 8'(TIMEOUT_CYCLES - 1));
    assign wdog_d      = stall ? wdog_q + 8'd1 : 8'd0;

    // Watchdog counter register
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) wdog_q <= 8'd0;
        else           wdog_q <= wdog_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State, owner and last-granted registers
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= OW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (|m_cyc_i) begin
                    owner_d = winner;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!own_cyc) begin
                    last_d  = owner_q;
                    state_d = StIdle;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = StDrain;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            StDrain: begin
                if (!own_cyc) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Output logic: slave side muxed from the owner only while in GRANT
    always_comb begin
        m_gnt_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        if (state_q == StGrant) begin
            m_gnt_o[owner_q] = 1'b1;
            m_ack_o[owner_q] = s_ack_i & own_cyc & own_stb;
            m_err_o[owner_q] = (s_err_i & own_cyc & own_stb) | timeout_hit;
            s_adr_o          = m_adr_i[32'(owner_q) * AW +: AW];
            s_dat_o          = m_dat_i[32'(owner_q) * DW +: DW];
            s_sel_o          = m_sel_i[32'(owner_q) * SW +: SW];
            s_cyc_o          = own_cyc;
            s_stb_o          = own_cyc & own_stb;
            s_we_o           = own_cyc & m_we_i[owner_q];
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (state_q == StDrain) begin
            m_gnt_o[owner_q] = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter: a round-robin instance and a
// fixed-priority instance share the same stimulus.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            wb_clk = 1'b0;
    logic            wb_rst_n;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [DW-1:0]   s_dat_in;
    logic            s_ack, s_err;

    logic [DW-1:0] m_dat_out, fp_m_dat_out;
    logic [N-1:0]  m_ack, m_err, m_gnt, fp_ack, fp_err, fp_gnt;
    logic [AW-1:0] s_adr, fp_s_adr;
    logic [DW-1:0] s_dat, fp_s_dat;
    logic [SW-1:0] s_sel, fp_s_sel;
    logic          s_cyc, s_stb, s_we, fp_s_cyc, fp_s_stb, fp_s_we;

    int total = 0;
    int bad   = 0;

    always #5 wb_clk = ~wb_clk;

    wb_rr_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_dat_o(m_dat_out), .m_ack_o(m_ack), .m_err_o(m_err), .m_gnt_o(m_gnt),
        .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_dat_i(s_dat_in), .s_ack_i(s_ack), .s_err_i(s_err)
    );

    wb_rr_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)
    ) dut_fp (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_dat_o(fp_m_dat_out), .m_ack_o(fp_ack), .m_err_o(fp_err), .m_gnt_o(fp_gnt),
        .s_adr_o(fp_s_adr), .s_dat_o(fp_s_dat), .s_sel_o(fp_s_sel),
        .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_we_o(fp_s_we),
        .s_dat_i(s_dat_in), .s_ack_i(s_ack), .s_err_i(s_err)
    );

    task automatic next_cycle;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        m_cyc[k]           = c;
        m_stb[k]           = s;
        m_we[k]            = w;
        m_adr[k*AW +: AW]  = a;
        m_dat[k*DW +: DW]  = d;
        m_sel[k*SW +: SW]  = 4'hF;
    endtask

    task automatic clear_inputs;
        m_adr = '0; m_dat = '0; m_sel = '0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_dat_in = '0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    // Reset asserted and released between clock edges
    task automatic do_reset;
        wb_rst_n = 1'b0;
        clear_inputs();
        @(posedge wb_clk);
        @(posedge wb_clk);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        wb_rst_n = 1'b0;
        clear_inputs();
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h55);
        s_ack = 1'b1;
        @(posedge wb_clk);
        #2;
        total++; if (m_gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", m_gnt); end
        total++; if (m_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b exp=0000", m_ack); end
        total++; if (m_err !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b exp=0000", m_err); end
        total++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin bad++; $display("FAIL reset_s_strobes got=%b exp=000", {s_cyc, s_stb, s_we}); end
        total++; if (s_adr !== 32'h0 || s_dat !== 32'h0 || s_sel !== 4'h0) begin bad++; $display("FAIL reset_s_bus got=%h/%h/%h exp=0/0/0", s_adr, s_dat, s_sel); end
        total++; if (fp_gnt !== 4'b0000) begin bad++; $display("FAIL reset_fp_gnt got=%b exp=0000", fp_gnt); end
    endtask

    task automatic test_single;
        do_reset();
        set_m(2, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        #1;
        total++; if (m_gnt !== 4'b0000) begin bad++; $display("FAIL single_pre_gnt got=%b exp=0000", m_gnt); end
        next_cycle();
        total++; if (m_gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=0100", m_gnt); end
        total++; if (s_adr !== 32'h100) begin bad++; $display("FAIL single_adr got=%h exp=00000100", s_adr); end
        total++; if (s_dat !== 32'hDEADBEEF) begin bad++; $display("FAIL single_dat got=%h exp=deadbeef", s_dat); end
        total++; if ({s_cyc, s_stb, s_we, s_sel} !== 7'b111_1111) begin bad++; $display("FAIL single_strobes got=%b exp=1111111", {s_cyc, s_stb, s_we, s_sel}); end
        total++; if (m_ack !== 4'b0000) begin bad++; $display("FAIL single_noack got=%b exp=0000", m_ack); end
        s_ack = 1'b1;
        s_dat_in = 32'hCAFEF00D;
        #1;
        total++; if (m_ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", m_ack); end
        total++; if (m_dat_out !== 32'hCAFEF00D) begin bad++; $display("FAIL single_rdata got=%h exp=cafef00d", m_dat_out); end
        s_ack = 1'b0;
        s_err = 1'b1;
        #1;
        total++; if (m_err !== 4'b0100) begin bad++; $display("FAIL single_err got=%b exp=0100", m_err); end
        m_stb[2] = 1'b0;
        #1;
        total++; if (m_err !== 4'b0000) begin bad++; $display("FAIL single_err_gated got=%b exp=0000", m_err); end
        s_err = 1'b0;
        next_cycle();
        m_cyc[2] = 1'b0;
        #1;
        total++; if (s_cyc !== 1'b0 || m_gnt !== 4'b0100) begin bad++; $display("FAIL single_drop got=%b/%b exp=0/0100", s_cyc, m_gnt); end
        next_cycle();
        total++; if (m_gnt !== 4'b0000) begin bad++; $display("FAIL single_release got=%b exp=0000", m_gnt); end
        next_cycle();
        total++; if (m_gnt !== 4'b0000) begin bad++; $display("FAIL single_stay_idle got=%b exp=0000", m_gnt); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        int         e;
        do_reset();
        for (int k = 0; k < 4; k++) set_m(k, 1'b1, 1'b1, 1'b0, 32'h1000 + k, 32'h0);
        for (int t = 0; t < 5; t++) begin
            e = t % 4;
            exp_gnt = 4'b0001 << e;
            next_cycle();
            total++; if (m_gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", t, m_gnt, exp_gnt); end
            total++; if (s_adr !== 32'h1000 + e) begin bad++; $display("FAIL rr_adr%0d got=%h exp=%h", t, s_adr, 32'h1000 + e); end
            s_ack = 1'b1;
            #1;
            total++; if (m_ack !== exp_gnt) begin bad++; $display("FAIL rr_ack%0d got=%b exp=%b", t, m_ack, exp_gnt); end
            next_cycle();
            s_ack = 1'b0;
            m_cyc[e] = 1'b0;
            m_stb[e] = 1'b0;
            next_cycle();
            total++; if (m_gnt !== 4'b0000) begin bad++; $display("FAIL rr_dead%0d got=%b exp=0000", t, m_gnt); end
            m_cyc[e] = 1'b1;
            m_stb[e] = 1'b1;
        end
    endtask

    task automatic test_fixed_priority;
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h11, 32'h0);
        set_m(3, 1'b1, 1'b1, 1'b0, 32'h33, 32'h0);
        for (int t = 0; t < 3; t++) begin
            next_cycle();
            total++; if (fp_gnt !== 4'b0010) begin bad++; $display("FAIL fp_gnt%0d got=%b exp=0010", t, fp_gnt); end
            s_ack = 1'b1;
            #1;
            total++; if (fp_ack !== 4'b0010) begin bad++; $display("FAIL fp_ack%0d got=%b exp=0010", t, fp_ack); end
            next_cycle();
            s_ack = 1'b0;
            m_cyc[1] = 1'b0;
            m_stb[1] = 1'b0;
            next_cycle();
            total++; if (fp_gnt !== 4'b0000) begin bad++; $display("FAIL fp_dead%0d got=%b exp=0000", t, fp_gnt); end
            m_cyc[1] = 1'b1;
            m_stb[1] = 1'b1;
        end
    endtask

    task automatic test_no_preempt;
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b1, 32'hA0, 32'h0A);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'hB0, 32'h0B);
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            s_ack = 1'b1;
            #1;
            total++; if (m_gnt !== 4'b0001 || m_ack !== 4'b0001) begin bad++; $display("FAIL np_beat%0d got=%b/%b exp=0001/0001", b, m_gnt, m_ack); end
            next_cycle();
        end
        s_ack = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        #1;
        total++; if (m_gnt !== 4'b0001 || s_cyc !== 1'b0) begin bad++; $display("FAIL np_drop got=%b/%b exp=0001/0", m_gnt, s_cyc); end
        next_cycle();
        total++; if (m_gnt !== 4'b0000) begin bad++; $display("FAIL np_dead got=%b exp=0000", m_gnt); end
        next_cycle();
        total++; if (m_gnt !== 4'b0010 || s_adr !== 32'hB0 || s_we !== 1'b0) begin bad++; $display("FAIL np_next got=%b/%h/%b exp=0010/000000b0/0", m_gnt, s_adr, s_we); end
    endtask

    task automatic test_async_reset;
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'hC0, 32'h0);
        next_cycle();
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        next_cycle();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'hC1, 32'h77);
        next_cycle();
        #1;
        total++; if (m_gnt !== 4'b0010 || s_cyc !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b/%b exp=0010/1", m_gnt, s_cyc); end
        #1;
        wb_rst_n = 1'b0;
        #1;
        total++; if (m_gnt !== 4'b0000 || {s_cyc, s_stb, s_we} !== 3'b000) begin bad++; $display("FAIL ar_async got=%b/%b exp=0000/000", m_gnt, {s_cyc, s_stb, s_we}); end
        total++; if (s_adr !== 32'h0 || s_dat !== 32'h0) begin bad++; $display("FAIL ar_bus got=%h/%h exp=0/0", s_adr, s_dat); end
        set_m(0, 1'b1, 1'b1, 1'b0, 32'hD0, 32'h0);
        set_m(2, 1'b1, 1'b1, 1'b0, 32'hD2, 32'h0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        next_cycle();
        total++; if (m_gnt !== 4'b0001 || s_adr !== 32'hD0) begin bad++; $display("FAIL ar_first got=%b/%h exp=0001/000000d0", m_gnt, s_adr); end
    endtask

    task automatic test_hung_slave;
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'hE0, 32'h0);
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            total++;
            if (m_err !== ((c == 8) ? 4'b0001 : 4'b0000) || s_cyc !== 1'b1) begin
                bad++;
                $display("FAIL to_stall%0d err got=%b cyc got=%b", c, m_err, s_cyc);
            end
        end
        next_cycle();
        total++; if ({s_cyc, s_stb} !== 2'b00 || m_err !== 4'b0000 || m_gnt !== 4'b0001) begin bad++; $display("FAIL to_drain got=%b/%b/%b exp=00/0000/0001", {s_cyc, s_stb}, m_err, m_gnt); end
        next_cycle();
        total++; if (m_gnt !== 4'b0001 || s_cyc !== 1'b0) begin bad++; $display("FAIL to_hold got=%b/%b exp=0001/0", m_gnt, s_cyc); end
`else
        for (int c = 0; c < 20; c++) next_cycle();
        total++; if (m_err !== 4'b0000 || s_cyc !== 1'b1 || m_gnt !== 4'b0001) begin bad++; $display("FAIL hung_hold got=%b/%b/%b exp=0000/1/0001", m_err, s_cyc, m_gnt); end
`endif
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        next_cycle();
        total++; if (m_gnt !== 4'b0000) begin bad++; $display("FAIL hung_release got=%b exp=0000", m_gnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_no_preempt();
        test_async_reset();
        test_hung_slave();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
